// File: rtl/j1_io_responder_pkg.sv
// j1_io_responder_pkg: register map, STATUS layout and helpers shared by the I/O responder
package j1_io_responder_pkg;
  localparam logic [15:0] ADDR_GPIO   = 16'h1000;
  localparam logic [15:0] ADDR_TXDATA = 16'h2000;
  localparam logic [15:0] ADDR_STATUS = 16'h2001;
  localparam logic [15:0] ADDR_RXDATA = 16'h2002;
  localparam logic [15:0] ADDR_TICKS  = 16'h4000;
  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_VALID  = 2;
  localparam int ST_OVERRUN   = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_W   = 5;
  localparam int TICKS_W      = 16;
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_GPIO,
    SEL_TXDATA,
    SEL_STATUS,
    SEL_RXDATA,
    SEL_TICKS
  } sel_e;
  // Full 16-bit decode; anything not listed is unmapped.
  function automatic sel_e decode(input logic [15:0] a);
    return a == ADDR_GPIO   ? SEL_GPIO   :
           a == ADDR_TXDATA ? SEL_TXDATA :
           a == ADDR_STATUS ? SEL_STATUS :
           a == ADDR_RXDATA ? SEL_RXDATA :
           a == ADDR_TICKS  ? SEL_TICKS  : SEL_NONE;
  endfunction
  function automatic logic [15:0] pack_status(
    input logic                  full,
    input logic                  empty,
    input logic                  rx_valid,
    input logic                  overrun,
    input logic [ST_COUNT_W-1:0] count
  );
    logic [15:0] s;
    s = '0;
    s[ST_TX_FULL] = full;
    s[ST_TX_EMPTY] = empty;
    s[ST_RX_VALID] = rx_valid;
    s[ST_OVERRUN] = overrun;
    s[ST_COUNT_LSB +: ST_COUNT_W] = count;
    return s;
  endfunction
endpackage

// File: rtl/io_fifo.sv
// io_fifo: byte FIFO for the TX path; a push while full is accepted only if a pop frees a slot that cycle
module io_fifo
  import j1_io_responder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [7:0]            i_data,
  output logic [7:0]            o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ST_COUNT_W-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [ST_COUNT_W-1:0] r_count;
  logic w_push, w_pop;
  assign o_full  = r_count == ST_COUNT_W'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= (w_push & ~w_pop) ? r_count + 1'b1 :
                 (w_pop & ~w_push) ? r_count - 1'b1 : r_count;
    end
  end
endmodule

// File: rtl/j1_io_responder.sv
// j1_io_responder: J1 CPU I/O slave with GPIO, TX FIFO, RX holding register and a tick counter
module j1_io_responder
  import j1_io_responder_pkg::*;
#(
  parameter int TX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  output logic [15:0] gpio,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_strobe
);
  sel_e w_sel;
  logic w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic [ST_COUNT_W-1:0] w_tx_count;
  logic w_rx_pop, w_ovr_clr, w_ovr_set;
  logic [15:0] w_rd_data;
  logic [TICKS_W-1:0] r_ticks;
  logic [7:0] r_rx_byte;
  logic r_rx_valid, r_overrun;
  assign w_sel     = decode(io_addr);
  assign w_tx_push = io_wr & (w_sel == SEL_TXDATA);
  assign w_rx_pop  = io_wr & (w_sel == SEL_RXDATA);
  assign w_ovr_clr = io_wr & (w_sel == SEL_STATUS);
  assign w_tx_pop  = tx_valid & tx_ready;
  assign tx_valid  = ~w_tx_empty;
  // A set event wins over a simultaneous clear, so overrun is never lost.
  assign w_ovr_set = (w_tx_push & w_tx_full & ~w_tx_pop) |
                     (rx_strobe & r_rx_valid & ~w_rx_pop);
  io_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk    (clk),
    .rst    (reset),
    .i_push (w_tx_push),
    .i_pop  (w_tx_pop),
    .i_data (io_dout[7:0]),
    .o_data (tx_data),
    .o_full (w_tx_full),
    .o_empty(w_tx_empty),
    .o_count(w_tx_count)
  );
  // Read mux over the current register values; registered below for 1-cycle latency.
  always_comb begin
    w_rd_data = '0;
    w_rd_data = w_sel == SEL_GPIO   ? gpio :
                w_sel == SEL_STATUS ? pack_status(w_tx_full, w_tx_empty, r_rx_valid, r_overrun, w_tx_count) :
                w_sel == SEL_RXDATA ? {8'h00, r_rx_byte} :
                w_sel == SEL_TICKS  ? r_ticks : 16'h0000;
  end
  // Read data register, GPIO register and free-running tick counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_din  <= '0;
      gpio    <= '0;
      r_ticks <= '0;
    end else begin
      io_din  <= w_rd_data;
      if (io_wr && w_sel == SEL_GPIO) gpio <= io_dout;
      r_ticks <= (io_wr && w_sel == SEL_TICKS) ? '0 : r_ticks + 1'b1;
    end
  end
  // RX holding register: an RXDATA write frees the slot for a byte arriving the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (rx_strobe && (!r_rx_valid || w_rx_pop)) begin
        r_rx_byte  <= rx_data;
        r_rx_valid <= 1'b1;
      end else if (w_rx_pop) begin
        r_rx_valid <= 1'b0;
      end
      r_overrun <= w_ovr_set | (r_overrun & ~w_ovr_clr);
    end
  end
endmodule

// File: tb/tb_j1_io_responder.sv
// tb_j1_io_responder: directed scoreboard bench for the J1 I/O responder
module tb_j1_io_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_wr = 1'b0;
  logic [15:0] io_addr = '0;
  logic [15:0] io_dout = '0;
  logic [15:0] io_din;
  logic [15:0] gpio;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_strobe = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic rd_now = 1'b0;
  logic rd_pend = 1'b0;
  logic [15:0] rd_q[$];
  string nm_q[$];
  logic [7:0] tx_q[$];
  localparam logic [15:0] A_GPIO = 16'h1000, A_TX = 16'h2000, A_ST = 16'h2001,
                          A_RX = 16'h2002, A_TK = 16'h4000;

  j1_io_responder #(.TX_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .io_wr(io_wr), .io_addr(io_addr), .io_dout(io_dout),
    .io_din(io_din), .gpio(gpio), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_strobe(rx_strobe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
    end
  endtask

  // Read monitor: io_din is checked one cycle after a read address was presented.
  always @(posedge clk) rd_pend <= rd_now;
  always @(negedge clk)
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rd_q_underflow: got io_din 0x%04h with nothing expected", io_din);
      end else chk(nm_q.pop_front(), io_din, rd_q.pop_front());
    end

  // TX monitor: every accepted byte must match the queued order.
  always @(negedge clk)
    if (!reset && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL tx_q_underflow: got tx_data 0x%02h with nothing expected", tx_data);
      end else chk("tx_data", {8'h00, tx_data}, {8'h00, tx_q.pop_front()});
    end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    io_wr = 1'b1; io_addr = a; io_dout = d;
    step();
    io_wr = 1'b0; io_addr = '0; io_dout = '0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string nm);
    io_addr = a; rd_now = 1'b1;
    rd_q.push_back(exp); nm_q.push_back(nm);
    step();
    rd_now = 1'b0; io_addr = '0;
  endtask

  task automatic push(input logic [7:0] b, input bit expect_out);
    if (expect_out) tx_q.push_back(b);
    wr(A_TX, {8'h00, b});
  endtask

  task automatic rx(input logic [7:0] b);
    rx_data = b; rx_strobe = 1'b1;
    step();
    rx_strobe = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    reset = 1'b0;
    chk("rst_gpio", gpio, 16'h0000);
    chk("rst_tx_valid", {15'b0, tx_valid}, 16'h0000);
    chk("rst_io_din", io_din, 16'h0000);
    rd(A_ST, 16'h0002, "rst_status");
    // GPIO write/read and unmapped read
    wr(A_GPIO, 16'hA5A5);
    chk("gpio_val", gpio, 16'hA5A5);
    chk("gpio_old_din", io_din, 16'h0000);
    rd(A_GPIO, 16'hA5A5, "gpio_rd");
    rd(16'h1001, 16'h0000, "unmapped_rd");
    rd(A_TX, 16'h0000, "txdata_rd");
    // FIFO ordering
    push(8'h11, 1); push(8'h22, 1); push(8'h33, 1);
    rd(A_ST, 16'h0030, "status_cnt3");
    tx_ready = 1'b1;
    repeat (3) step();
    tx_ready = 1'b0;
    chk("drain_tx_valid", {15'b0, tx_valid}, 16'h0000);
    rd(A_ST, 16'h0002, "status_drained");
    // Fill past full, then push+pop when full, then clear overrun
    for (int i = 1; i <= 9; i++) push(8'(i), i <= 8);
    rd(A_ST, 16'h0089, "status_full_ovr");
    tx_q.push_back(8'h0A);
    io_wr = 1'b1; io_addr = A_TX; io_dout = 16'h000A; tx_ready = 1'b1;
    step();
    io_wr = 1'b0; io_addr = '0; tx_ready = 1'b0;
    rd(A_ST, 16'h0089, "status_pushpop_full");
    wr(A_ST, 16'hFFFF);
    rd(A_ST, 16'h0081, "status_ovr_clr");
    tx_ready = 1'b1;
    repeat (8) step();
    tx_ready = 1'b0;
    rd(A_ST, 16'h0002, "status_wrap_drained");
    // RX holding register
    rx(8'h41); rx(8'h42);
    rd(A_RX, 16'h0041, "rx_keep_old");
    rd(A_ST, 16'h000E, "status_rx_ovr");
    rx_data = 8'h43; rx_strobe = 1'b1;
    wr(A_RX, 16'h0000);
    rx_strobe = 1'b0;
    rd(A_RX, 16'h0043, "rx_pop_capture");
    rd(A_ST, 16'h000E, "status_rx_valid_kept");
    wr(A_ST, 16'h0000);
    rd(A_ST, 16'h0006, "status_rx_ovr_clr");
    wr(A_RX, 16'h0000);
    rd(A_ST, 16'h0002, "status_rx_popped");
    rd(A_RX, 16'h0043, "rx_byte_kept");
    rx(8'h44);
    rx_data = 8'h45; rx_strobe = 1'b1;
    wr(A_ST, 16'h0000);
    rx_strobe = 1'b0;
    rd(A_ST, 16'h000E, "status_set_beats_clr");
    rd(A_RX, 16'h0044, "rx_no_overwrite");
    // TICKS timing and wrap
    wr(A_TK, 16'h0000);
    repeat (2) step();
    rd(A_TK, 16'h0002, "ticks_n3");
    repeat (65535) step();
    rd(A_TK, 16'h0002, "ticks_wrap");
    // Reset with traffic in flight
    wr(A_ST, 16'h0000);
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), 0);
    rx(8'h55);
    wr(A_GPIO, 16'h1234);
    reset = 1'b1; io_wr = 1'b1; io_addr = A_GPIO; io_dout = 16'hFFFF;
    rx_strobe = 1'b1; rx_data = 8'h66; tx_ready = 1'b1;
    step();
    reset = 1'b0; io_wr = 1'b0; io_addr = '0; rx_strobe = 1'b0; tx_ready = 1'b0;
    chk("rst2_tx_valid", {15'b0, tx_valid}, 16'h0000);
    chk("rst2_gpio", gpio, 16'h0000);
    chk("rst2_io_din", io_din, 16'h0000);
    rd(A_TK, 16'h0000, "rst2_ticks");
    rd(A_ST, 16'h0002, "rst2_status");
    repeat (3) step();
    chk("rd_q_empty", 16'(rd_q.size()), 16'h0000);
    chk("tx_q_empty", 16'(tx_q.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
